// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizing for the register-file writeback controller.
package regfile_wb_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_STARVE_LIMIT  = 3;

  // One writeback request: destination register and its value.
  typedef struct packed {
    logic [DEF_ADDRESS_WIDTH-1:0] rd;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } wb_req_t;

  // Arbiter state: ALU normally wins; MEM_FORCE steals one cycle for the load FIFO.
  typedef enum logic [0:0] {
    ALU_PRI   = 1'b0,
    MEM_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with occupancy, full and empty flags.
// Push when full and pop when empty are ignored.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter type T     = wb_req_t,
  parameter int  DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage write.
  // NOTE: the storage array has no reset; a flush only clears pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the integer register file.
// ALU results have priority; loads queue in a FIFO and are forced through after
// STARVE_LIMIT consecutive ALU grants or when the FIFO fills. Keeps the
// destination busy scoreboard used by decode.
// Optional build macro REGFILE_WB_FORWARD_EN adds a write-port forwarding path.
module regfile_wb_ctrl
  import regfile_wb_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDRESS_WIDTH-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]      issue_rd,
  output logic                          RegWrite,
  output logic [ADDRESS_WIDTH-1:0]      wa,
  output logic [DATA_WIDTH-1:0]         wd,
  output logic [2**ADDRESS_WIDTH-1:0]   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef REGFILE_WB_FORWARD_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0]      fwd_ra1,
  input  logic [ADDRESS_WIDTH-1:0]      fwd_ra2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [DATA_WIDTH-1:0]         fwd_data1,
  output logic [DATA_WIDTH-1:0]         fwd_data2
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } req_t;

  arb_state_e                state, state_nxt;
  logic [SW-1:0]             starve_cnt, starve_nxt;
  logic [CW-1:0]             count_nxt;
  logic                      fifo_full, fifo_empty;
  logic                      mem_push;
  logic                      grant_alu, grant_mem, grant;
  logic                      commit;
  req_t                      mem_req, head;
  logic [ADDRESS_WIDTH-1:0]  win_rd;
  logic [DATA_WIDTH-1:0]     win_data;
  logic [2**ADDRESS_WIDTH-1:0] busy_nxt;

  assign mem_req   = '{rd: mem_rd, data: mem_data};
  assign mem_ready = !fifo_full;
  assign mem_push  = mem_valid && mem_ready;

  wb_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_push),
    .push_data (mem_req),
    .pop       (grant_mem),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Arbitration: pick the winner, advance the starvation counter, choose next state.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    alu_ready  = (state == ALU_PRI);
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    starve_nxt = starve_cnt;
    state_nxt  = ALU_PRI;
    count_nxt  = fifo_count;
    unique case (state)
      ALU_PRI: begin
        if (alu_valid) begin
          grant_alu = 1'b1;
          if (!fifo_empty) starve_nxt = starve_cnt + SW'(1);
        end else if (!fifo_empty) begin
          grant_mem  = 1'b1;
          starve_nxt = '0;
        end
        count_nxt = fifo_count + CW'(mem_push) - CW'(grant_mem);
        if ((count_nxt != '0) && ((starve_nxt == LIMIT_C) || (count_nxt == DEPTH_C)))
          state_nxt = MEM_FORCE;
      end
      MEM_FORCE: begin
        grant_mem  = 1'b1;
        starve_nxt = '0;
        state_nxt  = ALU_PRI;
      end
      default: state_nxt = ALU_PRI;
    endcase
  end

  assign grant    = grant_alu || grant_mem;
  assign win_rd   = grant_alu ? alu_rd   : head.rd;
  assign win_data = grant_alu ? alu_data : head.data;
  assign commit   = grant && (win_rd != '0);

  // Arbiter state and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ALU_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Register-file write port: one-cycle pulse per granted non-x0 request; x0 leaves wa/wd untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      RegWrite <= commit;
      if (commit) begin
        wa <= win_rd;
        wd <= win_data;
      end
    end
  end

  // Scoreboard update: commit clears, then issue sets, so a same-cycle issue to that rd wins.
  always_comb begin
    busy_nxt = busy;
    if (commit) busy_nxt[win_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef REGFILE_WB_FORWARD_EN
  // Bypass the value being written this cycle to reads made before the falling-edge capture.
  assign fwd_hit1  = RegWrite && (wa == fwd_ra1) && (fwd_ra1 != '0);
  assign fwd_hit2  = RegWrite && (wa == fwd_ra2) && (fwd_ra2 != '0);
  assign fwd_data1 = wd;
  assign fwd_data2 = wd;
`else
  // Forwarding path not built.
`endif

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writeback controller and write-side initiator for the integer register file.
- Accepts writeback requests from two producers:
  - ALU pipe: low latency, priority.
  - Load/memory unit: buffered in a small FIFO.
- Arbitrates both onto the register file's single write port (RegWrite/wa/wd).
- Keeps a destination-register busy scoreboard that decode uses for hazard stalls.

Parameters:
- DATA_WIDTH, 64: register data width.
- ADDRESS_WIDTH, 5: register index width; 2**ADDRESS_WIDTH registers.
- FIFO_DEPTH, 4: memory-writeback FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 3: consecutive ALU grants allowed while the FIFO is non-empty before memory is forced.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  memory writeback request.
- mem_ready  out  1  FIFO not full (registered-state derived).
- mem_rd  in  ADDRESS_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- issue_valid  in  1  decode issued an instruction that writes issue_rd.
- issue_rd  in  ADDRESS_WIDTH  destination being marked pending.
- RegWrite  out  1  register-file write enable (registered).
- wa  out  ADDRESS_WIDTH  write address (registered).
- wd  out  DATA_WIDTH  write data (registered).
- busy  out  2**ADDRESS_WIDTH  pending-write scoreboard, one bit per register (registered).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  memory FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - RegWrite=0, wa=0, wd=0, busy=0, fifo_count=0.
  - Starvation counter = 0; arbiter state = ALU_PRI.
  - Asserting reset mid-operation flushes all buffered FIFO entries; no write is issued for them.
- Handshakes:
  - A transfer occurs when valid && ready at a rising edge.
  - Producers hold rd/data stable while valid && !ready.
- mem_ready = (fifo_count != FIFO_DEPTH).
- Push and pop in the same cycle leave fifo_count unchanged.
- No FIFO bypass: a memory request accepted in cycle N pops no earlier than N+1.
- Arbiter states:
  - ALU_PRI: alu_ready=1.
    - If alu_valid: ALU wins; starvation counter increments when the FIFO is non-empty.
    - Else, if the FIFO is non-empty: head pops and the counter clears.
    - Transition to MEM_FORCE when the FIFO is non-empty and (counter == STARVE_LIMIT or FIFO full).
  - MEM_FORCE: alu_ready=0; head pops unconditionally; counter clears; next state is ALU_PRI.
- Write port:
  - A granted request in cycle N sets RegWrite=1, wa=rd, wd=data in cycle N+1, for exactly one cycle.
  - The register file captures on the falling edge of that cycle.
  - Result: ALU latency 1 cycle; memory latency ≥2 cycles.
- x0 handling:
  - A granted request with rd==0 completes its handshake, but RegWrite stays 0 and wa/wd hold their previous values.
  - busy[0] is always 0.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A granted request with rd!=0 clears busy[rd] at the same edge RegWrite is registered.
  - Issue and commit to the same rd in the same cycle: set wins (newer producer outstanding).
- Idle cycle (no grant): RegWrite=0.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined: adds inputs fwd_ra1/fwd_ra2 (ADDRESS_WIDTH) and outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (DATA_WIDTH).
  - fwd_hitN = RegWrite && wa==fwd_raN && fwd_raN!=0, combinational.
  - fwd_dataN = wd.
  - Covers reads in the half-cycle before the register file's falling-edge write.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package regfile_wb_pkg:
  - wb_req_t struct {rd, data}.
  - Arbiter state enum {ALU_PRI, MEM_FORCE}.
  - Default width constants.
- One sub-module: wb_fifo (parameterised synchronous FIFO of wb_req_t, with count/full/empty outputs).

Test Plan:
- Reset mid-stream:
  - Stimulus: 3 loads buffered, reset pulsed low.
  - Response: fifo_count=0, busy=0, RegWrite=0; no write issued after release.
- ALU single write:
  - Stimulus: alu_valid, rd=5, data=64'hDEAD_BEEF in cycle N.
  - Response: RegWrite=1, wa=5, wd=DEAD_BEEF in N+1 only; busy[5] clears at that edge.
- Starvation:
  - Stimulus: alu_valid held every cycle, one load (rd=7) queued.
  - Response: 3 ALU grants, then alu_ready=0 for one cycle and the load writes wa=7.
- FIFO full:
  - Stimulus: 4 loads pushed while ALU is busy.
  - Response: mem_ready=0, fifo_count=4; the next cycle forces a memory pop regardless of counter.
- x0 write:
  - Stimulus: alu_rd=0, data=1.
  - Response: alu_ready=1, RegWrite stays 0, busy unchanged.
- Scoreboard race:
  - Stimulus: issue_rd=9 in the same cycle an ALU write to rd=9 is granted.
  - Response: busy[9]=1 afterwards.
